led_blink_scheduler: RTL

Shares the board's single status LED among NREQ requesters in the QPSK design; each requester asks to display a blink code (1–15 pulses). Round-robin arbitration selects a requester in idle; a prescaler derives a slow tick from clk, and a blink sequencer plays the latched code as ON/OFF pulses followed by a gap, then acknowledges. It replaces a free-running LED divider with a scheduled, multi-source indicator.

---
 rtl/led_blink_scheduler_pkg.sv | 13 +
 rtl/led_blink_scheduler_rr_arbiter.sv | 28 ++
 rtl/led_sched_defs.vh | 9 +
 rtl/led_blink_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/led_blink_scheduler_pkg.sv
// Shared widths, state encodings and helpers for the status-LED blink scheduler.
package led_blink_scheduler_pkg;
  `include "led_sched_defs.vh"

  localparam int PRESC_W = 26;
  localparam int PHASE_W = 8;
  localparam int ID_W    = 2;
  localparam int NUM_REQ = 4;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/led_blink_scheduler_rr_arbiter.sv
// Combinational 4-way round-robin arbiter: highest priority is last_grant+1,
// wrapping, so last_grant itself is considered last.
module rr_arbiter
  import led_blink_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_eligible,
  input  logic [ID_W-1:0]    last_grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] cand;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = last_grant;
    cand        = last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last_grant + ID_W'(k);
      if (req_eligible[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

endmodule

// File: rtl/led_sched_defs.vh
// FSM state encodings and blink-code width shared by the LED scheduler files.
`ifndef LED_SCHED_DEFS_VH
`define LED_SCHED_DEFS_VH
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_ON   = 2'd1;
localparam logic [1:0] ST_OFF  = 2'd2;
localparam logic [1:0] ST_GAP  = 2'd3;
localparam int         CODE_W  = 4;
`endif

// File: rtl/led_blink_scheduler.sv
// Shares one status LED among four requesters: round-robin grant in idle, then
// plays the latched blink code as ON/OFF pulses on a prescaled tick, a gap, and an ack.
module led_blink_scheduler
  import led_blink_scheduler_pkg::*;
#(
  parameter int TICK_DIV  = 4000000,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 3,
  parameter int GAP_TICKS = 10,
  parameter int NREQ      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [CODE_W*NREQ-1:0] code,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  output logic [1:0]             cur_id,
  output logic                   led
);

  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PHASE_W-1:0] ON_LAST   = PHASE_W'(ON_TICKS - 1);
  localparam logic [PHASE_W-1:0] OFF_LAST  = PHASE_W'(OFF_TICKS - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(GAP_TICKS - 1);

  logic [1:0]         state;
  logic [ID_W-1:0]    last_grant;
  logic [PRESC_W-1:0] presc;
  logic [PHASE_W-1:0] phase;
  logic [CODE_W-1:0]  pulses_left;
  logic               tick;

  logic [NREQ-1:0]    req_eligible;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [CODE_W-1:0]  code_sel;

  // A requester being acked this cycle must not be regranted in the same cycle.
  assign req_eligible = req & ~ack;
  assign code_sel     = code[CODE_W*grant_id +: CODE_W];
  assign tick         = (presc == TICK_LAST);

  rr_arbiter u_arb (
    .req_eligible (req_eligible),
    .last_grant   (last_grant),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= ID_W'(NREQ - 1);
      cur_id      <= '0;
      presc       <= '0;
      phase       <= '0;
      pulses_left <= '0;
      led         <= 1'b0;
      ack         <= '0;
      busy        <= 1'b0;
    end else begin
      ack <= '0;
      if (state != ST_IDLE) begin
        presc <= tick ? '0 : presc + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          busy <= grant_valid;
          if (grant_valid) begin
            cur_id      <= grant_id;
            last_grant  <= grant_id;
            presc       <= '0;
            phase       <= '0;
            pulses_left <= code_sel;
            if (code_sel != '0) begin
              state <= ST_ON;
              led   <= 1'b1;
            end else begin
              ack <= id_onehot(grant_id);
            end
          end
        end

        ST_ON: begin
          if (tick) begin
            if (phase == ON_LAST) begin
              phase <= '0;
              led   <= 1'b0;
              if (pulses_left == CODE_W'(1)) begin
                state <= ST_GAP;
              end else begin
                pulses_left <= pulses_left - 1'b1;
                state       <= ST_OFF;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end

        ST_OFF: begin
          if (tick) begin
            if (phase == OFF_LAST) begin
              phase <= '0;
              led   <= 1'b1;
              state <= ST_ON;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end

        ST_GAP: begin
          // busy stays high through the ack cycle that follows.
          if (tick) begin
            if (phase == GAP_LAST) begin
              phase <= '0;
              state <= ST_IDLE;
              ack   <= id_onehot(cur_id);
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
